// File: rtl/addsub_batch_acc_pkg.sv
// Shared types and constants for the batch accumulator and its add/subtract stage.
package addsub_batch_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned W_DFLT = 5;

  // Saturation limits for a w-bit two's-complement value, zero-extended to 32 bits.
  function automatic logic [31:0] maxpos(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] maxneg(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_ovf.sv
// Combinational W-bit ripple add/subtract with signed-overflow output.
module addsub_ovf
  import addsub_batch_acc_pkg::*;
#(
  parameter int unsigned W = W_DFLT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         v
);

  logic [W-1:0] b_eff;
  logic [W:0]   c;

  always_comb begin
    b_eff = (sub == OP_ADD) ? b : ~b;
    c     = '0;
    c[0]  = sub;
    s     = '0;
    for (int unsigned i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
    // Overflow: carry out of the MSB disagrees with carry into it.
    v = c[W] ^ c[W-1];
  end

endmodule

// File: rtl/addsub_batch_acc.sv
// Batch accumulator: sums LEN signed add/sub operands, emits one result per batch
// with a sticky overflow flag over a valid/ready handshake.
module addsub_batch_acc
  import addsub_batch_acc_pkg::*;
#(
  parameter int unsigned W   = W_DFLT,
  parameter int unsigned LEN = 4,
  parameter int unsigned SAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_op,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic [3:0]   out_cnt
);

  localparam logic [W-1:0] SAT_POS = W'(maxpos(W));
  localparam logic [W-1:0] SAT_NEG = W'(maxneg(W));
  localparam logic [3:0]   LEN_C   = 4'(LEN);

  state_t       state_q;
  logic [W-1:0] acc_q;
  logic [3:0]   cnt_q;
  logic         sticky_q;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         out_ovf_q;
  logic [3:0]   out_cnt_q;

  logic [W-1:0] op_a;
  logic [W-1:0] sum;
  logic         ovf;
  logic [W-1:0] acc_d;
  logic [3:0]   cnt_d;
  logic         accept;

  assign in_ready = !rst && (state_q != EMIT);
  assign accept   = in_valid && in_ready;

  // IDLE always computes from zero so a fresh batch never sees stale state.
  assign op_a = (state_q == IDLE) ? '0 : acc_q;

  addsub_ovf #(.W(W)) u_addsub (
    .a  (op_a),
    .b  (in_data),
    .sub(in_op),
    .s  (sum),
    .v  (ovf)
  );

  always_comb begin
    acc_d = sum;
    if (ovf && (SAT != 0)) begin
      acc_d = op_a[W-1] ? SAT_NEG : SAT_POS;
    end
    cnt_d = (state_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= ovf;
            if (cnt_d == LEN_C) begin
              state_q     <= EMIT;
              out_valid_q <= 1'b1;
              out_data_q  <= acc_d;
              out_ovf_q   <= ovf;
              out_cnt_q   <= cnt_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_q | ovf;
          end
          if ((accept && (cnt_d == LEN_C)) || flush) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
            out_data_q  <= accept ? acc_d : acc_q;
            out_ovf_q   <= sticky_q | (accept & ovf);
            out_cnt_q   <= accept ? cnt_d : cnt_q;
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_addsub_batch_acc.sv
// Bench for addsub_batch_acc: four instances (LEN 4/1 x wrap/sat) under shared stimulus.
module tb_addsub_batch_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_op;
  logic       flush;
  logic       out_ready;

  logic       ir [4];
  logic       ov [4];
  logic [4:0] od [4];
  logic       oo [4];
  logic [3:0] oc [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    addsub_batch_acc #(
      .W  (5),
      .LEN((g < 2) ? 4 : 1),
      .SAT((g % 2 == 1) ? 1 : 0)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_data  (in_data),
      .in_op    (in_op),
      .flush    (flush),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_data (od[g]),
      .out_ovf  (oo[g]),
      .out_cnt  (oc[g])
    );
  end

  function automatic int len_of(input int i);
    return (i < 2) ? 4 : 1;
  endfunction

  function automatic bit sat_of(input int i);
    return (i % 2) == 1;
  endfunction

  // Reference model: plain integer arithmetic, range check for overflow.
  int m_acc [4];
  int m_cnt [4];
  bit m_stk [4];
  bit m_emit[4];
  int m_od  [4];
  bit m_oo  [4];
  int m_oc  [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_stk[i] = 0; m_emit[i] = 0;
        m_od[i] = 0; m_oo[i] = 0; m_oc[i] = 0;
      end else if (m_emit[i]) begin
        if (out_ready) begin
          m_emit[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_stk[i] = 0;
        end
      end else begin
        bit was_acc;
        was_acc = m_cnt[i] > 0;
        if (in_valid) begin
          int d, r;
          bit o;
          d = int'($signed(in_data));
          r = in_op ? m_acc[i] - d : m_acc[i] + d;
          o = (r > 15) || (r < -16);
          if (o) begin
            if (sat_of(i)) r = (m_acc[i] < 0) ? -16 : 15;
            else           r = (r > 15) ? r - 32 : r + 32;
          end
          m_acc[i] = r;
          m_cnt[i] = m_cnt[i] + 1;
          m_stk[i] = m_stk[i] | o;
        end
        if ((in_valid && m_cnt[i] == len_of(i)) || (flush && was_acc)) begin
          m_emit[i] = 1;
          m_od[i] = m_acc[i]; m_oo[i] = m_stk[i]; m_oc[i] = m_cnt[i];
        end
      end
    end
  end

  task automatic push(input logic [4:0] d, input logic op);
    in_valid = 1'b1; in_data = d; in_op = op;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_op = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ir[i] !== 1'b0 || ov[i] !== 1'b0 || od[i] !== 5'd0 || oo[i] !== 1'b0 || oc[i] !== 4'd0) begin
        n_bad++;
        $display("FAIL reset inst%0d: ir=%b ov=%b od=%h oo=%b oc=%0d, required all zero", i, ir[i], ov[i], od[i], oo[i], oc[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap_basic();
    test_reset();
    out_ready = 1'b1;
    push(5'd3, 1'b0); push(5'd4, 1'b0); push(5'd5, 1'b0); push(5'd2, 1'b0);
    n_cmp++;
    if (ov[0] !== 1'b1 || od[0] !== 5'd14 || oo[0] !== 1'b0 || oc[0] !== 4'd4 || ir[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_basic: ov=%b od=%0d oo=%b oc=%0d ir=%b, required 1 14 0 4 0", ov[0], od[0], oo[0], oc[0], ir[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_consume: ov=%b ir=%b, required 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_wrap_ovf();
    test_reset();
    out_ready = 1'b1;
    push(5'd7, 1'b0); push(5'd7, 1'b0); push(5'd3, 1'b0); push(5'h1F, 1'b0);
    n_cmp++;
    if (ov[0] !== 1'b1 || od[0] !== 5'b10000 || oo[0] !== 1'b1 || oc[0] !== 4'd4) begin
      n_bad++;
      $display("FAIL wrap_ovf: ov=%b od=%b oo=%b oc=%0d, required 1 10000 1 4", ov[0], od[0], oo[0], oc[0]);
    end
  endtask

  task automatic test_sat();
    test_reset();
    out_ready = 1'b1;
    push(5'd15, 1'b0); push(5'd1, 1'b0); push(5'd1, 1'b1); push(5'd0, 1'b0);
    n_cmp++;
    if (ov[1] !== 1'b1 || od[1] !== 5'd14 || oo[1] !== 1'b1 || oc[1] !== 4'd4) begin
      n_bad++;
      $display("FAIL sat: ov=%b od=%0d oo=%b oc=%0d, required 1 14 1 4", ov[1], od[1], oo[1], oc[1]);
    end
  endtask

  task automatic test_len1();
    test_reset();
    out_ready = 1'b0;
    push(5'b10000, 1'b1);
    n_cmp++;
    if (ov[2] !== 1'b1 || od[2] !== 5'b10000 || oo[2] !== 1'b1 || oc[2] !== 4'd1) begin
      n_bad++;
      $display("FAIL len1_wrap: ov=%b od=%b oo=%b oc=%0d, required 1 10000 1 1", ov[2], od[2], oo[2], oc[2]);
    end
    n_cmp++;
    if (ov[3] !== 1'b1 || od[3] !== 5'b01111 || oo[3] !== 1'b1 || oc[3] !== 4'd1) begin
      n_bad++;
      $display("FAIL len1_sat: ov=%b od=%b oo=%b oc=%0d, required 1 01111 1 1", ov[3], od[3], oo[3], oc[3]);
    end
  endtask

  task automatic test_flush();
    test_reset();
    out_ready = 1'b1;
    push(5'd2, 1'b0); push(5'd3, 1'b0);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b1 || od[0] !== 5'd5 || oc[0] !== 4'd2 || oo[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_partial: ov=%b od=%0d oc=%0d oo=%b, required 1 5 2 0", ov[0], od[0], oc[0], oo[0]);
    end
    @(negedge clk);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (ov[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_idle: ov=%b, required 0", ov[0]);
      end
      @(negedge clk);
    end
    push(5'd1, 1'b0);
    flush = 1'b1; push(5'd4, 1'b0); flush = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b1 || od[0] !== 5'd5 || oc[0] !== 4'd2) begin
      n_bad++;
      $display("FAIL flush_accept: ov=%b od=%0d oc=%0d, required 1 5 2", ov[0], od[0], oc[0]);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    out_ready = 1'b0;
    push(5'd1, 1'b0); push(5'd2, 1'b0); push(5'd3, 1'b0); push(5'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ov[0] !== 1'b1 || od[0] !== 5'd10 || oc[0] !== 4'd4 || ir[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure cyc%0d: ov=%b od=%0d oc=%0d ir=%b, required 1 10 4 0", k, ov[0], od[0], oc[0], ir[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: ov=%b ir=%b, required 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    out_ready = 1'b0;
    push(5'd5, 1'b0); push(5'd6, 1'b0);
    rst = 1'b1; @(negedge clk);
    n_cmp++;
    if (ov[0] !== 1'b0 || od[0] !== 5'd0 || oc[0] !== 4'd0 || ir[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: ov=%b od=%0d oc=%0d ir=%b, required 0 0 0 0", ov[0], od[0], oc[0], ir[0]);
    end
    rst = 1'b0; @(negedge clk);
    push(5'd1, 1'b0); push(5'd1, 1'b0); push(5'd1, 1'b0); push(5'd1, 1'b0);
    n_cmp++;
    if (ov[0] !== 1'b1 || od[0] !== 5'd4 || oc[0] !== 4'd4 || oo[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_next_batch: ov=%b od=%0d oc=%0d oo=%b, required 1 4 4 0", ov[0], od[0], oc[0], oo[0]);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ov[i] !== m_emit[i] ||
            (m_emit[i] && (int'($signed(od[i])) != m_od[i] || oo[i] !== m_oo[i] || int'(oc[i]) != m_oc[i]))) begin
          n_bad++;
          $display("FAIL random c%0d inst%0d: ov=%b od=%0d oo=%b oc=%0d, required %b %0d %b %0d",
                   c, i, ov[i], $signed(od[i]), oo[i], oc[i], m_emit[i], m_od[i], m_oo[i], m_oc[i]);
        end
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 5'($urandom);
      in_op     = 1'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ir[i] !== !m_emit[i]) begin
          n_bad++;
          $display("FAIL random_ready c%0d inst%0d: ir=%b, required %b", c, i, ir[i], !m_emit[i]);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_wrap_basic();
    test_wrap_ovf();
    test_sat();
    test_len1();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
